// File: rtl/ones_count_sequencer_if.sv
// Handshake bundle between the ones-count sequencer and its environment:
// input stream, counter Start/Ready link, result port and running total.
interface ones_count_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4,
   parameter int TOT_W  = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] cnt_data;
   logic              cnt_start;
   logic              cnt_ready;
   logic [CNT_W-1:0]  cnt_count;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [CNT_W-1:0]  res_count;
   logic [TOT_W-1:0]  total;
   logic              clear_total;
   logic              busy;

   modport master (
      output in_valid, in_data, cnt_ready, cnt_count, res_ready, clear_total,
      input  in_ready, cnt_data, cnt_start, res_valid, res_data, res_count, total, busy
   );

   modport slave (
      input  in_valid, in_data, cnt_ready, cnt_count, res_ready, clear_total,
      output in_ready, cnt_data, cnt_start, res_valid, res_data, res_count, total, busy
   );
endinterface

// File: rtl/ones_count_sequencer.sv
// Buffers input words, feeds them one at a time to the ones counter over its
// Start/Ready handshake, and returns each count with a saturating running total.
module ones_count_sequencer #(
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TOT_W      = 12
) (
   input logic                 clock,
   input logic                 reset,
   ones_count_sequencer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [4:0] IDLE      = 5'b00001;
   localparam logic [4:0] ISSUE     = 5'b00010;
   localparam logic [4:0] WAIT_BUSY = 5'b00100;
   localparam logic [4:0] WAIT_DONE = 5'b01000;
   localparam logic [4:0] OUTPUT    = 5'b10000;

   logic [4:0]        state;
   logic [4:0]        state_next;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic              full;
   logic              empty;
   logic              accept;
   logic              push;
   logic              pop;
   logic              capture;
   logic              consume;
   logic [DATA_W-1:0] word_reg;
   logic [DATA_W-1:0] res_data_reg;
   logic [CNT_W-1:0]  res_count_reg;
   logic              res_valid_reg;
   logic [TOT_W-1:0]  total_reg;
   logic [TOT_W-1:0]  total_base;
   logic [TOT_W:0]    total_sum;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign accept  = !full && !reset;
   assign push    = bus.in_valid && accept;
   assign pop     = (state == IDLE) && !empty && bus.cnt_ready;
   assign capture = (state == WAIT_DONE) && bus.cnt_ready;
   assign consume = (state == OUTPUT) && res_valid_reg && bus.res_ready;

   // A clear coinciding with a capture wipes the old total before adding.
   assign total_base = bus.clear_total ? '0 : total_reg;
   assign total_sum  = {1'b0, total_base} + {{(TOT_W + 1 - CNT_W){1'b0}}, bus.cnt_count};

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (pop) state_next = ISSUE;
         ISSUE:     state_next = WAIT_BUSY;
         WAIT_BUSY: if (!bus.cnt_ready) state_next = WAIT_DONE;
         WAIT_DONE: if (bus.cnt_ready) state_next = OUTPUT;
         OUTPUT:    if (consume) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= bus.in_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         word_reg      <= '0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
         res_count_reg <= '0;
         total_reg     <= '0;
      end else begin
         state <= state_next;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            word_reg <= mem[rd_ptr[PTR_W-1:0]];
         end
         if (capture) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= word_reg;
            res_count_reg <= bus.cnt_count;
            total_reg     <= total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];
         end else begin
            if (consume) res_valid_reg <= 1'b0;
            if (bus.clear_total) total_reg <= '0;
         end
      end
   end

   assign bus.in_ready  = accept;
   assign bus.cnt_data  = word_reg;
   assign bus.cnt_start = (state == ISSUE);
   assign bus.res_valid = res_valid_reg;
   assign bus.res_data  = res_data_reg;
   assign bus.res_count = res_count_reg;
   assign bus.total     = total_reg;
   assign bus.busy      = (state != IDLE) || !empty;
endmodule
